commit_trace_fifo: RTL and testbench

Captures architectural commit events from `trivial_mips` and serialises them into a single ordered trace stream for difftest against golden `.ans` files, on the simulation bench or on the board through a UART/debug link. Each cycle it samples the register-file write request, the HI/LO write request and the data-bus write strobe. It packs up to three simultaneous events, in a fixed order, into a circular buffer and drains them one per cycle through a valid/ready handshake. It sits directly downstream of the CPU core's writeback and memory ports.

---
 rtl/commit_trace_fifo_pkg.sv | 31 +++
 rtl/commit_trace_fifo_if.sv | 13 +
 rtl/commit_trace_fifo_mpush_buf.sv | 51 +++++
 rtl/commit_trace_fifo.sv | 109 ++++++++++
 tb/tb_commit_trace_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_fifo_pkg.sv
// Shared types for the commit trace capture path.
// Contents: trace kind enum, trace entry payload, CPU write-request structs.
package commit_trace_fifo_pkg;

   typedef enum logic [1:0] {
      TR_REG  = 2'd0,
      TR_HILO = 2'd1,
      TR_MEM  = 2'd2
   } TraceKind_t;

   typedef struct packed {
      TraceKind_t  kind;
      logic [31:0] tag;
      logic [63:0] data;
   } TraceEntry_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } RegWriteReq_t;

   typedef struct packed {
      logic        we;
      logic [63:0] hilo;
   } HiloWriteReq_t;

   // Maximum events captured in one cycle (REG, HILO, MEM)
   localparam int unsigned PUSH_PORTS = 3;

endpackage

// File: rtl/commit_trace_fifo_if.sv
// Trace output stream, valid/ready handshake.
// Signals: valid (head entry present), ready (consumer accepts), entry (head payload).
// Modports: master = trace producer, slave = trace consumer.
interface commit_trace_fifo_if;
   import commit_trace_fifo_pkg::*;

   logic        valid;
   logic        ready;
   TraceEntry_t entry;

   modport master (output valid, output entry, input ready);
   modport slave  (input valid, input entry, output ready);
endinterface

// File: rtl/commit_trace_fifo_mpush_buf.sv
// trace_mpush_buf: circular buffer with 3 compacted write ports, 1 read port.
// Ports: clk, rst (async, active-high); wr_en/wr_cnt/wr_data write a group of
// wr_cnt entries from slots 0..wr_cnt-1; rd_en pops the head; rd_data is the
// head slot; level is the current occupancy.
module trace_mpush_buf
   import commit_trace_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [1:0]             wr_cnt,
   input  TraceEntry_t            wr_data [PUSH_PORTS],
   input  logic                   rd_en,
   output TraceEntry_t            rd_data,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   TraceEntry_t   mem [DEPTH];

   // Extra pointer MSB distinguishes full from empty; wraps modulo 2*DEPTH
   assign level   = wptr - rptr;
   assign rd_data = mem[rptr[AW-1:0]];

   // Pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + PW'(wr_cnt);
         if (rd_en) rptr <= rptr + PW'(1);
      end
   end

   // Storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < PUSH_PORTS; i++) begin
            if (2'(i) < wr_cnt) mem[AW'(wptr + PW'(i))] <= wr_data[i];
         end
      end
   end

endmodule

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: captures REG / HILO / MEM commit events each cycle,
// packs them in fixed order into a circular buffer and drains one per cycle.
// Ports: clk, rst (async, active-high); reg_wr, hilo_wr, mem_we/mem_addr/
// mem_wdata event inputs; trace (master modport: valid/ready/entry);
// overflow (sticky), drop_cnt (saturating), clear_ovf; level (occupancy).
// Build option: TRACE_HILO_EN enables capture of HI/LO write events.
module commit_trace_fifo
   import commit_trace_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  RegWriteReq_t            reg_wr,
   input  HiloWriteReq_t           hilo_wr,
   input  logic                    mem_we,
   input  logic [31:0]             mem_addr,
   input  logic [31:0]             mem_wdata,
   commit_trace_fifo_if.master     trace,
   output logic                    overflow,
   output logic [CNT_W-1:0]        drop_cnt,
   input  logic                    clear_ovf,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic        reg_ev;
   logic        hilo_ev;
   logic        mem_ev;
   TraceEntry_t reg_e;
   TraceEntry_t hilo_e;
   TraceEntry_t mem_e;
   TraceEntry_t slot [PUSH_PORTS];
   logic [1:0]  n;
   logic        admit;
   logic        drop;
   logic        rd_en;
   TraceEntry_t head;

   // Event qualification; writes to $0 are architecturally invisible
   assign reg_ev = reg_wr.we && (reg_wr.waddr != 5'd0);
   assign mem_ev = mem_we;
   assign reg_e  = '{kind: TR_REG, tag: {27'b0, reg_wr.waddr}, data: {32'b0, reg_wr.wdata}};
   assign mem_e  = '{kind: TR_MEM, tag: mem_addr, data: {32'b0, mem_wdata}};

`ifdef TRACE_HILO_EN
   assign hilo_ev = hilo_wr.we;
   assign hilo_e  = '{kind: TR_HILO, tag: 32'b0, data: hilo_wr.hilo};
`else
   logic unused_hilo;
   assign unused_hilo = ^hilo_wr;
   assign hilo_ev     = 1'b0;
   assign hilo_e      = '0;
`endif

   // Compact qualified events into the low slots in REG, HILO, MEM order
   always_comb begin
      n = 2'd0;
      for (int i = 0; i < PUSH_PORTS; i++) slot[i] = '0;
      if (reg_ev) begin
         slot[n] = reg_e;
         n       = n + 2'd1;
      end
      if (hilo_ev) begin
         slot[n] = hilo_e;
         n       = n + 2'd1;
      end
      if (mem_ev) begin
         slot[n] = mem_e;
         n       = n + 2'd1;
      end
   end

   // All-or-nothing admission against start-of-cycle free space
   assign admit = (n != 2'd0) && ((LW'(DEPTH) - level) >= LW'(n));
   assign drop  = (n != 2'd0) && !admit;

   assign trace.valid = (level != '0);
   assign rd_en       = trace.valid && trace.ready;
   assign trace.entry = trace.valid ? head : '0;

   trace_mpush_buf #(.DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (admit),
      .wr_cnt  (n),
      .wr_data (slot),
      .rd_en   (rd_en),
      .rd_data (head),
      .level   (level)
   );

   // Sticky overflow and saturating drop counter; clear wins over a drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_commit_trace_fifo;
   import commit_trace_fifo_pkg::*;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned LW      = $clog2(DEPTH) + 1;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef TRACE_HILO_EN
   localparam bit HILO_EN = 1'b1;
`else
   localparam bit HILO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   RegWriteReq_t     reg_wr;
   HiloWriteReq_t    hilo_wr;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             overflow;
   logic [CNT_W-1:0] drop_cnt;
   logic             clear_ovf;
   logic [LW-1:0]    level;

   commit_trace_fifo_if trace_bus ();

   commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .reg_wr    (reg_wr),
      .hilo_wr   (hilo_wr),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .trace     (trace_bus),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clear_ovf (clear_ovf),
      .level     (level)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   TraceEntry_t q[$];
   bit          m_ovf;
   int          m_drop;

   function automatic TraceEntry_t mk(TraceKind_t k, logic [31:0] t, logic [63:0] d);
      TraceEntry_t e;
      e.kind = k; e.tag = t; e.data = d;
      return e;
   endfunction

   task automatic idle_inputs();
      reg_wr    = '0;
      hilo_wr   = '0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      clear_ovf = 1'b0;
   endtask

   task automatic rand_inputs();
      reg_wr.we    = $urandom_range(0, 1) == 1;
      reg_wr.waddr = 5'($urandom_range(0, 31));
      reg_wr.wdata = $urandom;
      hilo_wr.we   = $urandom_range(0, 1) == 1;
      hilo_wr.hilo = {$urandom, $urandom};
      mem_we       = $urandom_range(0, 1) == 1;
      mem_addr     = $urandom;
      mem_wdata    = $urandom;
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   // Apply the current inputs to the model, then advance one clock; returns entries admitted
   task automatic tick(output int pushed);
      TraceEntry_t grp[$];
      int lvl;
      lvl    = q.size();
      pushed = 0;
      if (reg_wr.we && reg_wr.waddr != 5'd0)
         grp.push_back(mk(TR_REG, {27'b0, reg_wr.waddr}, {32'b0, reg_wr.wdata}));
      if (HILO_EN && hilo_wr.we)
         grp.push_back(mk(TR_HILO, 32'b0, hilo_wr.hilo));
      if (mem_we)
         grp.push_back(mk(TR_MEM, mem_addr, {32'b0, mem_wdata}));
      if (trace_bus.ready && lvl != 0) void'(q.pop_front());
      if (grp.size() != 0) begin
         if (int'(DEPTH) - lvl >= grp.size()) begin
            foreach (grp[i]) q.push_back(grp[i]);
            pushed = grp.size();
         end else if (!clear_ovf) begin
            m_ovf = 1'b1;
            if (m_drop < CNT_MAX) m_drop++;
         end
      end
      if (clear_ovf) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      trace_bus.ready = 1'b0;
      idle_inputs();
      model_reset();
      #3;
      checks++; if (trace_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", trace_bus.valid); end
      checks++; if (trace_bus.entry !== '0) begin errors++; $display("FAIL reset_entry: got %h expected 0", trace_bus.entry); end
      checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_reg();
      int p;
      trace_bus.ready = 1'b1;
      reg_wr = '{we: 1'b1, waddr: 5'd3, wdata: 32'h1234};
      tick(p);
      idle_inputs();
      checks++; if (trace_bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", trace_bus.valid); end
      checks++; if (trace_bus.entry !== mk(TR_REG, 32'd3, 64'h1234)) begin errors++; $display("FAIL single_entry: got %h expected %h", trace_bus.entry, mk(TR_REG, 32'd3, 64'h1234)); end
      tick(p);
      checks++; if (trace_bus.valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", trace_bus.valid); end
   endtask

   task automatic test_zero_filter();
      int p;
      reg_wr = '{we: 1'b1, waddr: 5'd0, wdata: 32'hFFFF};
      tick(p);
      idle_inputs();
      checks++; if (level !== '0) begin errors++; $display("FAIL zero_level: got %0d expected 0", level); end
      checks++; if (trace_bus.valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b expected 0", trace_bus.valid); end
   endtask

   task automatic test_triple();
      TraceEntry_t exp[$];
      int p;
      trace_bus.ready = 1'b0;
      reg_wr  = '{we: 1'b1, waddr: 5'd2, wdata: 32'h5};
      hilo_wr = '{we: 1'b1, hilo: 64'hA_0000000B};
      mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD;
      tick(p);
      idle_inputs();
      exp.push_back(mk(TR_REG, 32'd2, 64'h5));
      if (HILO_EN) exp.push_back(mk(TR_HILO, 32'd0, 64'hA_0000000B));
      exp.push_back(mk(TR_MEM, 32'h100, 64'hDEAD));
      checks++; if (level !== LW'(exp.size())) begin errors++; $display("FAIL triple_level: got %0d expected %0d", level, exp.size()); end
      trace_bus.ready = 1'b1;
      foreach (exp[i]) begin
         checks++; if (trace_bus.entry !== exp[i]) begin errors++; $display("FAIL triple_entry%0d: got %h expected %h", i, trace_bus.entry, exp[i]); end
         tick(p);
      end
      checks++; if (trace_bus.valid !== 1'b0) begin errors++; $display("FAIL triple_drained: got %b expected 0", trace_bus.valid); end
   endtask

   task automatic test_overflow();
      int p;
      trace_bus.ready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         reg_wr = '{we: 1'b1, waddr: 5'($urandom_range(1, 31)), wdata: $urandom};
         tick(p);
      end
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_full_level: got %0d expected %0d", level, DEPTH); end
      reg_wr = '{we: 1'b1, waddr: 5'd7, wdata: 32'hBAD0}; mem_we = 1'b1;
      tick(p);
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      checks++; if (drop_cnt !== CNT_W'(1)) begin errors++; $display("FAIL ovf_drop1: got %0d expected 1", drop_cnt); end
      tick(p);
      checks++; if (drop_cnt !== CNT_W'(2)) begin errors++; $display("FAIL ovf_drop2: got %0d expected 2", drop_cnt); end
      // A full buffer popping this cycle still drops the group
      trace_bus.ready = 1'b1; mem_we = 1'b0;
      tick(p);
      checks++; if (drop_cnt !== CNT_W'(m_drop)) begin errors++; $display("FAIL ovf_pop_drop: got %0d expected %0d", drop_cnt, m_drop); end
      checks++; if (level !== LW'(q.size())) begin errors++; $display("FAIL ovf_pop_level: got %0d expected %0d", level, q.size()); end
      // Clear coinciding with a drop wins
      trace_bus.ready = 1'b0;
      tick(p);
      reg_wr = '{we: 1'b1, waddr: 5'd9, wdata: 32'h1}; mem_we = 1'b1; clear_ovf = 1'b1;
      tick(p);
      idle_inputs();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
      checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL clr_drop_cnt: got %0d expected 0", drop_cnt); end
      trace_bus.ready = 1'b1;
      for (int i = 0; i < 40 && q.size() != 0; i++) begin
         checks++; if (trace_bus.entry !== q[0]) begin errors++; $display("FAIL ovf_drain: got %h expected %h", trace_bus.entry, q[0]); end
         tick(p);
      end
      checks++; if (trace_bus.valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", trace_bus.valid); end
   endtask

   task automatic test_admit_boundary();
      int p;
      trace_bus.ready = 1'b0;
      for (int i = 0; i < int'(DEPTH) - 2; i++) begin
         mem_we = 1'b1; mem_addr = 32'(i * 4); mem_wdata = $urandom;
         tick(p);
      end
      // Two free slots: a 2-event group fits
      reg_wr = '{we: 1'b1, waddr: 5'd4, wdata: 32'h44}; mem_we = 1'b1;
      tick(p);
      idle_inputs();
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL bnd_fit_level: got %0d expected %0d", level, DEPTH); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bnd_fit_ovf: got %b expected 0", overflow); end
      trace_bus.ready = 1'b1;
      tick(p);
      tick(p);
      // Two free slots: a 3-event group (2 without HILO capture) is judged against them
      reg_wr = '{we: 1'b1, waddr: 5'd5, wdata: 32'h55}; hilo_wr = '{we: 1'b1, hilo: 64'h1}; mem_we = 1'b1;
      trace_bus.ready = 1'b0;
      tick(p);
      idle_inputs();
      checks++; if (level !== LW'(q.size())) begin errors++; $display("FAIL bnd_grp_level: got %0d expected %0d", level, q.size()); end
      checks++; if (drop_cnt !== CNT_W'(m_drop)) begin errors++; $display("FAIL bnd_grp_drop: got %0d expected %0d", drop_cnt, m_drop); end
      clear_ovf = 1'b1;
      trace_bus.ready = 1'b1;
      for (int i = 0; i < 40 && q.size() != 0; i++) begin
         checks++; if (trace_bus.entry !== q[0]) begin errors++; $display("FAIL bnd_drain: got %h expected %h", trace_bus.entry, q[0]); end
         tick(p);
         clear_ovf = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      TraceEntry_t prev;
      int p;
      trace_bus.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         reg_wr = '{we: 1'b1, waddr: 5'(i + 10), wdata: $urandom};
         tick(p);
      end
      idle_inputs();
      for (int i = 0; i < 12 && q.size() != 0; i++) begin
         prev = trace_bus.entry;
         trace_bus.ready = (i % 2 == 1);
         tick(p);
         if (i % 2 == 0) begin
            checks++; if (trace_bus.entry !== prev) begin errors++; $display("FAIL bp_stable: got %h expected %h", trace_bus.entry, prev); end
         end
         if (q.size() != 0) begin
            checks++; if (trace_bus.entry !== q[0]) begin errors++; $display("FAIL bp_order: got %h expected %h", trace_bus.entry, q[0]); end
         end
      end
      checks++; if (trace_bus.valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", trace_bus.valid); end
   endtask

   task automatic test_random();
      TraceEntry_t exp;
      int pushed = 0;
      int p;
      for (int cyc = 0; cyc < 600 && (pushed < 60 || q.size() != 0); cyc++) begin
         if (pushed < 60) rand_inputs(); else idle_inputs();
         trace_bus.ready = ($urandom_range(0, 3) != 0);
         clear_ovf = ($urandom_range(0, 15) == 0);
         tick(p);
         pushed += p;
         exp = (q.size() != 0) ? q[0] : '0;
         checks++; if (level !== LW'(q.size())) begin errors++; $display("FAIL rnd_level cyc %0d: got %0d expected %0d", cyc, level, q.size()); end
         checks++; if (trace_bus.valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, trace_bus.valid, q.size() != 0); end
         checks++; if (trace_bus.entry !== exp) begin errors++; $display("FAIL rnd_entry cyc %0d: got %h expected %h", cyc, trace_bus.entry, exp); end
         checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc %0d: got %b expected %b", cyc, overflow, m_ovf); end
         checks++; if (drop_cnt !== CNT_W'(m_drop)) begin errors++; $display("FAIL rnd_drop_cnt cyc %0d: got %0d expected %0d", cyc, drop_cnt, m_drop); end
      end
      idle_inputs();
      checks++; if (pushed < 40) begin errors++; $display("FAIL rnd_volume: got %0d expected >=40", pushed); end
   endtask

   task automatic test_reset_midstream();
      int p;
      trace_bus.ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mem_we = 1'b1; mem_addr = $urandom; mem_wdata = $urandom;
         tick(p);
      end
      idle_inputs();
      checks++; if (level !== LW'(5)) begin errors++; $display("FAIL rstm_pre_level: got %0d expected 5", level); end
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++; if (trace_bus.valid !== 1'b0) begin errors++; $display("FAIL rstm_valid: got %b expected 0", trace_bus.valid); end
      checks++; if (level !== '0) begin errors++; $display("FAIL rstm_level: got %0d expected 0", level); end
      @(negedge clk);
      rst = 1'b0;
      trace_bus.ready = 1'b1;
      reg_wr = '{we: 1'b1, waddr: 5'd31, wdata: 32'hC0FFEE};
      tick(p);
      idle_inputs();
      checks++; if (trace_bus.valid !== 1'b1) begin errors++; $display("FAIL rstm_post_valid: got %b expected 1", trace_bus.valid); end
      checks++; if (trace_bus.entry !== mk(TR_REG, 32'd31, 64'hC0FFEE)) begin errors++; $display("FAIL rstm_post_entry: got %h expected %h", trace_bus.entry, mk(TR_REG, 32'd31, 64'hC0FFEE)); end
      tick(p);
   endtask

   initial begin
      test_reset();
      test_single_reg();
      test_zero_filter();
      test_triple();
      test_overflow();
      test_admit_boundary();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
